// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the timer sequencer.
//   state_t        : sequencer FSM encoding (IDLE, RUN, GAP)
//   TW_DEFAULT     : default interval / timer-count width
//   DEPTH_DEFAULT  : default number of interval table entries
//   COUNT_MAX      : largest sequence length the default table can hold
//   clamp_count()  : limits a requested sequence length to the table depth
package timer_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int TW_DEFAULT    = 16;
    localparam int DEPTH_DEFAULT = 4;

    localparam logic [2:0] COUNT_MAX = 3'(DEPTH_DEFAULT);

    // A requested length above the table depth acts as the table depth.
    function automatic logic [2:0] clamp_count(input logic [2:0] cnt, input int depth);
        if (int'(cnt) > depth) begin
            return 3'(depth);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/timer_sequencer_regfile.sv
// Interval table: DEPTH entries of TW bits.
//   clk, rst_n : clock and synchronous active-low reset (clears all entries)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
// Because the read is combinational from the stored array, a read and a
// write of the same entry in one cycle returns the old contents.
module interval_regfile #(
    parameter int TW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [1:0]    waddr,
    input  logic [TW-1:0] wdata,
    input  logic [1:0]    raddr,
    output logic [TW-1:0] rdata
);

    logic [TW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/timer_sequencer.sv
// Timer sequencer: steps an external Timer through a table of intervals.
// Each table entry is one RUN segment (start_o high, n_o = interval); the
// segment ends when the Timer raises end_i. Segments are separated by a
// single-cycle GAP with start_o low. Optionally loops over the sequence.
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_we_i/addr/data    : interval table write port (any state)
//   count_i, loop_i       : sequence length and loop mode, sampled at each
//                           segment completion
//   go_i, abort_i         : start (IDLE only) / immediate stop
//   end_i                 : Timer end flag
//   n_o, start_o          : registered interval and start level to the Timer
//   busy_o, seg_idx_o     : activity and active table index
//   seg_done_o, seq_done_o: completion pulses
//   loop_cnt_o            : completed passes in loop mode
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter int TW    = TW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we_i,
    input  logic [1:0]    cfg_addr_i,
    input  logic [TW-1:0] cfg_data_i,
    input  logic [2:0]    count_i,
    input  logic          loop_i,
    input  logic          go_i,
    input  logic          abort_i,
    input  logic          end_i,
    output logic [TW-1:0] n_o,
    output logic          start_o,
    output logic          busy_o,
    output logic [1:0]    seg_idx_o,
    output logic          seg_done_o,
    output logic          seq_done_o,
    output logic [15:0]   loop_cnt_o
);

    state_t        state;
    logic          arm;
    logic [1:0]    rd_addr;
    logic [TW-1:0] rd_data;
    logic [2:0]    cnt_eff;
    logic [2:0]    idx_plus;
    logic          is_last;

    // IDLE always loads entry 0; GAP loads the already-advanced index.
    assign rd_addr = (state == ST_IDLE) ? 2'd0 : seg_idx_o;

    interval_regfile #(
        .TW    (TW),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cfg_we_i),
        .waddr (cfg_addr_i),
        .wdata (cfg_data_i),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // A length shrunk below the current index (or 0) mid-sequence is
    // treated as "this is the last segment".
    assign cnt_eff  = clamp_count(count_i, DEPTH);
    assign idx_plus = {1'b0, seg_idx_o} + 3'd1;
    assign is_last  = (idx_plus >= cnt_eff);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            arm        <= 1'b0;
            n_o        <= '0;
            start_o    <= 1'b0;
            busy_o     <= 1'b0;
            seg_idx_o  <= 2'd0;
            seg_done_o <= 1'b0;
            seq_done_o <= 1'b0;
            loop_cnt_o <= 16'd0;
        end else begin
            seg_done_o <= 1'b0;
            seq_done_o <= 1'b0;

            if (abort_i) begin
                state   <= ST_IDLE;
                start_o <= 1'b0;
                busy_o  <= 1'b0;
                arm     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (go_i && (count_i != 3'd0)) begin
                            state      <= ST_RUN;
                            seg_idx_o  <= 2'd0;
                            n_o        <= rd_data;
                            start_o    <= 1'b1;
                            busy_o     <= 1'b1;
                            loop_cnt_o <= 16'd0;
                            arm        <= 1'b0;
                        end
                    end

                    ST_RUN: begin
                        // The first RUN cycle may still see the previous
                        // segment's end flag; it is ignored until armed.
                        arm <= 1'b1;
                        if (arm && end_i) begin
                            seg_done_o <= 1'b1;
                            start_o    <= 1'b0;
                            if (!is_last) begin
                                state     <= ST_GAP;
                                seg_idx_o <= seg_idx_o + 2'd1;
                            end else if (loop_i) begin
                                state      <= ST_GAP;
                                seg_idx_o  <= 2'd0;
                                loop_cnt_o <= loop_cnt_o + 16'd1;
                            end else begin
                                state      <= ST_IDLE;
                                busy_o     <= 1'b0;
                                seq_done_o <= 1'b1;
                            end
                        end
                    end

                    ST_GAP: begin
                        state   <= ST_RUN;
                        n_o     <= rd_data;
                        start_o <= 1'b1;
                        arm     <= 1'b0;
                    end

                    default: begin
                        state   <= ST_IDLE;
                        start_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
module tb_timer_sequencer;

    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we_i;
    logic [1:0]    cfg_addr_i;
    logic [TW-1:0] cfg_data_i;
    logic [2:0]    count_i;
    logic          loop_i;
    logic          go_i;
    logic          abort_i;
    logic          end_i;
    logic [TW-1:0] n_o;
    logic          start_o;
    logic          busy_o;
    logic [1:0]    seg_idx_o;
    logic          seg_done_o;
    logic          seq_done_o;
    logic [15:0]   loop_cnt_o;

    always #5 clk = ~clk;

    timer_sequencer #(.TW(TW), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we_i   (cfg_we_i),
        .cfg_addr_i (cfg_addr_i),
        .cfg_data_i (cfg_data_i),
        .count_i    (count_i),
        .loop_i     (loop_i),
        .go_i       (go_i),
        .abort_i    (abort_i),
        .end_i      (end_i),
        .n_o        (n_o),
        .start_o    (start_o),
        .busy_o     (busy_o),
        .seg_idx_o  (seg_idx_o),
        .seg_done_o (seg_done_o),
        .seq_done_o (seq_done_o),
        .loop_cnt_o (loop_cnt_o)
    );

    // Timer model: counts while start is high, end flag rises once the
    // count reaches the interval and drops when start drops.
    int   tcnt = 0;
    logic tend = 1'b0;
    logic use_model;
    logic man_end;

    always @(posedge clk) begin
        if (!start_o) begin
            tcnt <= 0;
            tend <= 1'b0;
        end else begin
            tcnt <= tcnt + 1;
            if (tcnt + 1 >= int'(n_o)) tend <= 1'b1;
        end
    end

    assign end_i = use_model ? tend : man_end;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit is_done;
        int n;
        int idx;
        bit chk_idx;
        int lc;
        bit seq;
    } ev_t;

    ev_t exp_q[$];

    task automatic push_start(input int n, input int idx, input int lc);
        ev_t e;
        e.is_done = 1'b0; e.n = n; e.idx = idx; e.chk_idx = 1'b1; e.lc = lc; e.seq = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int idx, input bit chk_idx, input int lc, input bit seq);
        ev_t e;
        e.is_done = 1'b1; e.n = 0; e.idx = idx; e.chk_idx = chk_idx; e.lc = lc; e.seq = seq;
        exp_q.push_back(e);
    endtask

    // Monitor: every segment start and every completion pulse is matched
    // against the next expected event.
    logic prev_start = 1'b0;
    int   gap_len = 0;
    int   seg_n = 0;

    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            prev_start = 1'b0;
            gap_len = 0;
        end else begin
            if (start_o && !prev_start) begin
                if (gap_len > 0) chk("gap_len", gap_len, 1);
                gap_len = 0;
                seg_n = int'(n_o);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start actual n_o=%0d idx=%0d required none", n_o, seg_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_start", 0, int'(e.is_done));
                    chk("start_n", int'(n_o), e.n);
                    chk("start_idx", int'(seg_idx_o), e.idx);
                    chk("start_loop_cnt", int'(loop_cnt_o), e.lc);
                end
            end else if (start_o && prev_start) begin
                chk("n_stable", int'(n_o), seg_n);
            end

            if (busy_o && !start_o) gap_len++;
            else if (!busy_o) gap_len = 0;

            if (seg_done_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_seg_done actual idx=%0d required none", seg_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_done", 1, int'(e.is_done));
                    if (e.chk_idx) chk("done_idx", int'(seg_idx_o), e.idx);
                    chk("done_loop_cnt", int'(loop_cnt_o), e.lc);
                    chk("done_seq", int'(seq_done_o), int'(e.seq));
                end
            end else if (seq_done_o) begin
                checks++; errors++;
                $display("FAIL lone_seq_done actual=1 required 0");
            end
            prev_start = start_o;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int addr, input int data);
        cfg_we_i = 1'b1; cfg_addr_i = 2'(addr); cfg_data_i = TW'(data);
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic go_pulse();
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy_o && k < budget) begin tick(); k++; end
        chk(name, int'(busy_o), 0);
    endtask

    task automatic wait_lc(input string name, input int v, input int budget);
        int k = 0;
        while (int'(loop_cnt_o) != v && k < budget) begin tick(); k++; end
        chk(name, int'(loop_cnt_o), v);
    endtask

    task automatic wait_run_idx(input string name, input int v, input int budget);
        int k = 0;
        while (!(start_o && int'(seg_idx_o) == v) && k < budget) begin tick(); k++; end
        chk(name, int'(start_o && int'(seg_idx_o) == v), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_n"}, int'(n_o), 0);
        chk({tag, "_start"}, int'(start_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_idx"}, int'(seg_idx_o), 0);
        chk({tag, "_seg_done"}, int'(seg_done_o), 0);
        chk({tag, "_seq_done"}, int'(seq_done_o), 0);
        chk({tag, "_loop_cnt"}, int'(loop_cnt_o), 0);
    endtask

    task automatic load_table();
        wr(0, 5); wr(1, 3); wr(2, 7); wr(3, 2);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = 2'd0; cfg_data_i = '0;
        count_i = 3'd0; loop_i = 1'b0; go_i = 1'b0; abort_i = 1'b0;
        use_model = 1'b1; man_end = 1'b0;
        tick(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        load_table();

        // Three-segment one-shot sequence
        count_i = 3'd3; loop_i = 1'b0;
        push_start(5, 0, 0); push_done(1, 1, 0, 0);
        push_start(3, 1, 0); push_done(2, 1, 0, 0);
        push_start(7, 2, 0); push_done(0, 0, 0, 1);
        go_pulse();
        wait_idle("seq_idle", 200);
        chk("seq_idle_start", int'(start_o), 0);

        // Loop mode, three passes of two segments
        count_i = 3'd2; loop_i = 1'b1;
        for (int p = 0; p < 3; p++) begin
            push_start(5, 0, p); push_done(1, 1, p, 0);
            push_start(3, 1, p); push_done(0, 1, p + 1, 0);
        end
        go_pulse();
        wait_lc("loop_cnt_3", 3, 300);
        do_abort();
        chk("loop_abort_busy", int'(busy_o), 0);

        // Table write during a running segment affects only the next load
        push_start(5, 0, 0); push_done(1, 1, 0, 0);
        push_start(3, 1, 0); push_done(0, 1, 1, 0);
        push_start(5, 0, 1); push_done(1, 1, 1, 0);
        push_start(9, 1, 1); push_done(0, 1, 2, 0);
        go_pulse();
        wait_run_idx("wr_seg1", 1, 100);
        wr(1, 9);
        chk("wr_n_holds", int'(n_o), 3);
        wait_lc("wr_loop_cnt_2", 2, 300);
        do_abort();
        wr(1, 3);

        // Abort in the same cycle as end during the second segment
        use_model = 1'b0;
        count_i = 3'd3; loop_i = 1'b0;
        push_start(5, 0, 0); push_done(1, 1, 0, 0); push_start(3, 1, 0);
        go_pulse();
        tick();
        man_end = 1'b1; tick();
        man_end = 1'b0; tick();
        tick();
        man_end = 1'b1; abort_i = 1'b1; tick();
        man_end = 1'b0; abort_i = 1'b0;
        chk("abort_start", int'(start_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_seg_done", int'(seg_done_o), 0);
        chk("abort_seq_done", int'(seq_done_o), 0);
        tick();
        chk("abort_seg_done_late", int'(seg_done_o), 0);

        // Stale end held across GAP into the first RUN cycle
        push_start(5, 0, 0); push_done(1, 1, 0, 0); push_start(3, 1, 0);
        go_pulse();
        tick();
        man_end = 1'b1; tick();
        tick();
        tick();
        man_end = 1'b0;
        chk("stale_seg_done", int'(seg_done_o), 0);
        chk("stale_start", int'(start_o), 1);
        chk("stale_idx", int'(seg_idx_o), 1);
        tick();
        chk("stale_seg_done_late", int'(seg_done_o), 0);
        do_abort();
        use_model = 1'b1;

        // Reset mid-RUN, then a run from the cleared table (interval 0)
        count_i = 3'd3; loop_i = 1'b0;
        push_start(5, 0, 0);
        go_pulse();
        tick();
        rst_n = 1'b0; tick();
        chk_all_zero("midreset");
        rst_n = 1'b1;
        count_i = 3'd1;
        push_start(0, 0, 0); push_done(0, 0, 0, 1);
        go_pulse();
        wait_idle("zero_idle", 100);

        // go with count 0 is ignored
        load_table();
        count_i = 3'd0;
        go_pulse();
        chk("cnt0_busy", int'(busy_o), 0);
        chk("cnt0_start", int'(start_o), 0);
        tick();
        chk("cnt0_busy_late", int'(busy_o), 0);

        // count 7 behaves as 4
        count_i = 3'd7; loop_i = 1'b0;
        push_start(5, 0, 0); push_done(1, 1, 0, 0);
        push_start(3, 1, 0); push_done(2, 1, 0, 0);
        push_start(7, 2, 0); push_done(3, 1, 0, 0);
        push_start(2, 3, 0); push_done(0, 0, 0, 1);
        go_pulse();
        wait_idle("cnt7_idle", 300);

        tick(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 Parameter TW, default 16: interval and timer-count width.
REQ-002 Parameter DEPTH, default 4: number of interval table entries.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cfg_we_i  input  1  table write strobe.
REQ-006 cfg_addr_i  input  2  table write index.
REQ-007 cfg_data_i  input  TW  interval value to write.
REQ-008 count_i  input  3  number of table entries in the sequence; values above DEPTH act as DEPTH.
REQ-009 loop_i  input  1  when 1, the sequence restarts at entry 0 after the last entry.
REQ-010 go_i  input  1  start the sequence; sampled in IDLE only.
REQ-011 abort_i  input  1  stop the sequence immediately.
REQ-012 end_i  input  1  end flag from the Timer (curr_end_q).
REQ-013 n_o  output  TW  interval to the Timer (n_i), registered.
REQ-014 start_o  output  1  start level to the Timer (start_i), registered.
REQ-015 busy_o  output  1  high in RUN and GAP.
REQ-016 seg_idx_o  output  2  index of the active entry.
REQ-017 seg_done_o  output  1  one-cycle pulse per completed segment.
REQ-018 seq_done_o  output  1  one-cycle pulse when a non-looping sequence finishes.
REQ-019 loop_cnt_o  output  16  number of completed passes in loop mode; wraps at 2^16.

Function
REQ-020 States: IDLE, RUN, GAP.
REQ-021 In IDLE: go_i=1 and count_i!=0 -> RUN next cycle with seg_idx_o=0, n_o=table[0], start_o=1, and loop_cnt_o cleared.
REQ-022 In IDLE: go_i with count_i=0 is ignored. go_i is ignored in RUN and in GAP.
REQ-023 start_o is 1 throughout RUN and 0 in IDLE and GAP. n_o is constant for the whole of a RUN segment.
REQ-024 An arm flag clears on RUN entry and sets after the first RUN cycle. end_i is honoured only when the arm flag is set, so a stale end from the previous segment is not counted.
REQ-025 In RUN, an honoured end_i=1 gives a seg_done_o pulse on the next cycle.
REQ-026 RUN, seg_idx < count-1 -> GAP, with seg_idx incremented.
REQ-027 RUN, seg_idx = count-1, loop_i=1 -> GAP, with seg_idx set to 0 and loop_cnt_o incremented.
REQ-028 RUN, seg_idx = count-1, loop_i=0 -> IDLE, with a seq_done_o pulse in the same cycle as seg_done_o.
REQ-029 GAP lasts exactly one cycle: start_o=0, n_o loads table[seg_idx], then -> RUN.
REQ-030 abort_i=1 in any state -> IDLE next cycle, with start_o=0 and no seg_done_o or seq_done_o pulse. abort_i takes priority over end_i and go_i in the same cycle.
REQ-031 Table writes are accepted in any state. A write takes effect on n_o only at the next load (REQ-021/REQ-029); the running segment is unaffected.
REQ-032 A write and a load of the same entry in the same cycle loads the old value.
REQ-033 count_i and loop_i are sampled at each segment completion, not latched at go_i.
REQ-034 An interval value of 0 is passed through unchanged; its handling is defined by the Timer.

Reset
REQ-035 When rst_n=0 at a clock edge: state becomes IDLE; n_o, start_o, busy_o, seg_idx_o, seg_done_o, seq_done_o, loop_cnt_o, the arm flag and all table entries become 0.
REQ-036 Reset mid-sequence behaves as REQ-035, with no done pulse emitted.

Structure
REQ-037 The state encoding, TW, DEPTH and the DEPTH-clamp helper constant shall live in a shared timer package.
REQ-038 The interval table shall be one sub-module, interval_regfile: DEPTH x TW, one synchronous write port and one combinational read port.

Verification
REQ-039 Segment sequence: table={5,3,7,2}, count=3, loop=0, go pulse, Timer model connected. Required: start_o high for three segments separated by single-cycle low gaps; n_o=5,3,7; three seg_done_o pulses; one seq_done_o pulse; then IDLE.
REQ-040 Loop mode: count=2, loop=1, run for three passes. Required: seg_idx_o goes 0,1,0,1,0,1 and loop_cnt_o reads 3 after the third pass.
REQ-041 Abort during the second segment in the same cycle as end_i=1. Required: no seg_done_o pulse, and start_o=0 with busy_o=0 on the next cycle.
REQ-042 Stale end: end_i held at 1 across GAP into the first RUN cycle. Required: no completion counted until the arm flag is set.
REQ-043 Write table[1]=9 while segment 1 (value 3) is running. Required: n_o stays 3 for that segment; the next pass loads 9.
REQ-044 Reset and boundary inputs: rst_n=0 mid-RUN makes all outputs 0; go_i with count=0 stays in IDLE; count=7 behaves as count=4.
